// File: rtl/spike_rate_monitor.sv
// Per-channel spike counter over manual or back-to-back auto windows. Counts are
// snapshotted at window close, then a sequential argmax scan finds the dominant channel.
module spike_rate_monitor #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 100,
  parameter int TICK_W  = 8,
  localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  spike_in,
  input  logic             mode_auto,
  input  logic             win_start,
  input  logic             win_stop,
  input  logic             rd_req,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             counting,
  output logic             snap_valid,
  output logic [IDX_W-1:0] dom_idx,
  output logic             dom_none,
  output logic [N_CH-1:0]  sat_flags
);

  typedef enum logic {IDLE, COUNT} state_e;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [TICK_W-1:0] WIN_LAST = TICK_W'(WIN_LEN - 1);

  state_e             state_q, state_d;
  logic               auto_q, auto_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [CNT_W-1:0]   live_q [N_CH];
  logic [CNT_W-1:0]   live_d [N_CH];
  logic [CNT_W-1:0]   live_inc [N_CH];
  logic [N_CH-1:0]    lsat_q, lsat_d, lsat_inc;
  logic               close;

  logic [CNT_W-1:0]   snap_q [N_CH];
  logic [N_CH-1:0]    sat_flags_q;
  logic               scan_act_q, done_q;
  logic [IDX_W-1:0]   scan_ptr_q, best_idx_q, dom_idx_q;
  logic [CNT_W-1:0]   best_val_q, scan_val;
  logic               dom_none_q, snap_valid_q;
  logic [CNT_W-1:0]   rd_data_q, rd_mux;
  logic               rd_valid_q;

  // Saturating per-channel increment; the sat bit records an attempt past max.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      live_inc[i] = live_q[i];
      lsat_inc[i] = lsat_q[i];
      if (spike_in[i]) begin
        if (live_q[i] == CNT_MAX) lsat_inc[i] = 1'b1;
        else                      live_inc[i] = live_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    auto_d  = auto_q;
    tick_d  = tick_q;
    lsat_d  = lsat_q;
    close   = 1'b0;
    for (int i = 0; i < N_CH; i++) live_d[i] = live_q[i];
    case (state_q)
      IDLE: begin
        if (win_start) begin
          state_d = COUNT;
          auto_d  = mode_auto;
          tick_d  = '0;
          lsat_d  = '0;
          for (int i = 0; i < N_CH; i++) live_d[i] = '0;
        end
      end
      COUNT: begin
        tick_d = tick_q + TICK_W'(1);
        lsat_d = lsat_inc;
        for (int i = 0; i < N_CH; i++) live_d[i] = live_inc[i];
        if (win_stop) begin
          close   = 1'b1;
          state_d = IDLE;
        end else if (auto_q && (tick_q == WIN_LAST)) begin
          close  = 1'b1;
          tick_d = '0;
          lsat_d = '0;
          for (int i = 0; i < N_CH; i++) live_d[i] = '0;
        end else if (win_start) begin
          tick_d = '0;
          lsat_d = '0;
          for (int i = 0; i < N_CH; i++) live_d[i] = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign scan_val = snap_q[scan_ptr_q];

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_CH; i++)
      if (rd_idx == IDX_W'(i)) rd_mux = snap_q[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      auto_q       <= 1'b0;
      tick_q       <= '0;
      lsat_q       <= '0;
      sat_flags_q  <= '0;
      scan_act_q   <= 1'b0;
      done_q       <= 1'b0;
      scan_ptr_q   <= '0;
      best_idx_q   <= '0;
      best_val_q   <= '0;
      dom_idx_q    <= '0;
      dom_none_q   <= 1'b1;
      snap_valid_q <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        live_q[i] <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      auto_q       <= auto_d;
      tick_q       <= tick_d;
      lsat_q       <= lsat_d;
      for (int i = 0; i < N_CH; i++) live_q[i] <= live_d[i];
      done_q       <= 1'b0;
      snap_valid_q <= 1'b0;
      // A close always (re)starts the scan, aborting any scan still in flight.
      if (close) begin
        for (int i = 0; i < N_CH; i++) snap_q[i] <= live_inc[i];
        sat_flags_q <= lsat_inc;
        scan_act_q  <= 1'b1;
        scan_ptr_q  <= '0;
        best_idx_q  <= '0;
        best_val_q  <= '0;
      end else if (scan_act_q) begin
        if (scan_val > best_val_q) begin
          best_val_q <= scan_val;
          best_idx_q <= scan_ptr_q;
        end
        if (scan_ptr_q == IDX_W'(N_CH - 1)) begin
          scan_act_q <= 1'b0;
          done_q     <= 1'b1;
        end else begin
          scan_ptr_q <= scan_ptr_q + IDX_W'(1);
        end
      end
      if (done_q && !close) begin
        dom_idx_q    <= best_idx_q;
        dom_none_q   <= (best_val_q == '0);
        snap_valid_q <= 1'b1;
      end
      rd_valid_q <= rd_req;
      rd_data_q  <= rd_req ? rd_mux : '0;
    end
  end

  assign counting   = (state_q == COUNT);
  assign snap_valid = snap_valid_q;
  assign dom_idx    = dom_idx_q;
  assign dom_none   = dom_none_q;
  assign sat_flags  = sat_flags_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Directed bench: default instance (auto/manual windows, reads, reset) and a
// narrow-count 6-channel instance (saturation, ties, out-of-range reads).
module tb_spike_rate_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sv_cnt0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: N_CH=4, CNT_W=8, WIN_LEN=100
  logic       rst_n0 = 1'b0, auto0 = 1'b0, start0 = 1'b0, stop0 = 1'b0, rdreq0 = 1'b0;
  logic [3:0] spike0 = '0;
  logic [1:0] rdidx0 = '0;
  logic [7:0] rddata0;
  logic       rdvalid0, counting0, sv0, none0;
  logic [1:0] dom0;
  logic [3:0] sat0;

  // Instance 1: N_CH=6, CNT_W=4, WIN_LEN=20
  logic       rst_n1 = 1'b0, auto1 = 1'b0, start1 = 1'b0, stop1 = 1'b0, rdreq1 = 1'b0;
  logic [5:0] spike1 = '0;
  logic [2:0] rdidx1 = '0;
  logic [3:0] rddata1;
  logic       rdvalid1, counting1, sv1, none1;
  logic [2:0] dom1;
  logic [5:0] sat1;

  always @(posedge clk) if (sv0 === 1'b1) sv_cnt0 <= sv_cnt0 + 1;

  spike_rate_monitor u0 (
    .clk(clk), .rst_n(rst_n0), .spike_in(spike0), .mode_auto(auto0),
    .win_start(start0), .win_stop(stop0), .rd_req(rdreq0), .rd_idx(rdidx0),
    .rd_data(rddata0), .rd_valid(rdvalid0), .counting(counting0),
    .snap_valid(sv0), .dom_idx(dom0), .dom_none(none0), .sat_flags(sat0)
  );

  spike_rate_monitor #(.N_CH(6), .CNT_W(4), .WIN_LEN(20), .TICK_W(8)) u1 (
    .clk(clk), .rst_n(rst_n1), .spike_in(spike1), .mode_auto(auto1),
    .win_start(start1), .win_stop(stop1), .rd_req(rdreq1), .rd_idx(rdidx1),
    .rd_data(rddata1), .rd_valid(rdvalid1), .counting(counting1),
    .snap_valid(sv1), .dom_idx(dom1), .dom_none(none1), .sat_flags(sat1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Steps until snap_valid of the chosen instance is seen; n=-1 if budget runs out.
  task automatic wait_sv(input bit inst, input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      step();
      if ((inst ? sv1 : sv0) === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic rd(input bit inst, input int idx, input int exp, input string tag);
    if (inst) begin rdreq1 = 1'b1; rdidx1 = idx[2:0]; end
    else      begin rdreq0 = 1'b1; rdidx0 = idx[1:0]; end
    step();
    check({tag, "_data"}, inst ? 32'(rddata1) : 32'(rddata0), exp);
    check({tag, "_valid"}, inst ? 32'(rdvalid1) : 32'(rdvalid0), 1);
    rdreq0 = 1'b0;
    rdreq1 = 1'b0;
  endtask

  int n, t1, t2, t3, svb;
  int exp_rd [4] = '{100, 100, 0, 0};

  initial begin
    step();
    step();
    // Reset values
    check("rst_rd_data", rddata0, 0);
    check("rst_rd_valid", rdvalid0, 0);
    check("rst_counting", counting0, 0);
    check("rst_snap_valid", sv0, 0);
    check("rst_dom_idx", dom0, 0);
    check("rst_dom_none", none0, 1);
    check("rst_sat", sat0, 0);
    rst_n0 = 1'b1;

    // Test 1: auto window of 4'b0011
    auto0 = 1'b1; start0 = 1'b1;
    step();
    start0 = 1'b0; auto0 = 1'b0; spike0 = 4'b0011;
    check("t1_counting", counting0, 1);
    repeat (99) step();
    check("t1_no_early_snap", sv0, 0);
    step();
    spike0 = 4'b0000;
    check("t1_still_counting", counting0, 1);
    wait_sv(0, 20, n);
    t1 = cyc;
    check("t1_snap_latency", n, 5);
    check("t1_dom_idx", dom0, 0);
    check("t1_dom_none", none0, 0);
    check("t1_sat", sat0, 0);
    // Test 6: back-to-back reads
    for (int i = 0; i < 4; i++) begin
      rdreq0 = 1'b1; rdidx0 = 2'(i);
      step();
      check($sformatf("t6_rd%0d_data", i), rddata0, exp_rd[i]);
      check($sformatf("t6_rd%0d_valid", i), rdvalid0, 1);
    end
    rdreq0 = 1'b0;
    step();
    check("t6_valid_drop", rdvalid0, 0);
    check("t1_one_pulse", sv_cnt0, 1);

    // Test 4: two empty auto windows
    wait_sv(0, 200, n);
    t2 = cyc;
    check("t4_dom_none_a", none0, 1);
    wait_sv(0, 200, n);
    t3 = cyc;
    check("t4_period_a", t2 - t1, 100);
    check("t4_period_b", t3 - t2, 100);
    check("t4_dom_none_b", none0, 1);
    check("t4_dom_idx", dom0, 0);

    // Test 5: reset at tick 50 of an auto window
    spike0 = 4'b1111;
    repeat (45) step();
    rst_n0 = 1'b0;
    step();
    rst_n0 = 1'b1; spike0 = 4'b0000;
    check("t5_counting", counting0, 0);
    check("t5_snap_valid", sv0, 0);
    check("t5_dom_none", none0, 1);
    check("t5_sat", sat0, 0);
    svb = sv_cnt0;
    repeat (10) step();
    check("t5_no_snap", sv_cnt0, svb);

    // Test 2: manual window of 30 cycles on ch2
    start0 = 1'b1;
    step();
    start0 = 1'b0; spike0 = 4'b0100;
    repeat (29) step();
    stop0 = 1'b1;
    step();
    stop0 = 1'b0; spike0 = 4'b0000;
    check("t2_counting", counting0, 0);
    wait_sv(0, 20, n);
    check("t2_snap_latency", n, 5);
    check("t2_dom_idx", dom0, 2);
    check("t2_dom_none", none0, 0);
    rd(0, 2, 30, "t2_ch2");
    rd(0, 0, 0, "t2_ch0");

    // Restart inside a manual window, with a read on the closing edge
    start0 = 1'b1;
    step();
    start0 = 1'b0; spike0 = 4'b0001;
    repeat (4) step();
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    repeat (2) step();
    stop0 = 1'b1; rdreq0 = 1'b1; rdidx0 = 2'd2;
    step();
    stop0 = 1'b0; rdreq0 = 1'b0; spike0 = 4'b0000;
    check("rs_old_snap_read", rddata0, 30);
    wait_sv(0, 20, n);
    check("rs_snap_latency", n, 5);
    rd(0, 0, 3, "rs_ch0");
    check("rs_dom_idx", dom0, 0);

    // Test 3: saturation on the 4-bit instance
    rst_n1 = 1'b1;
    check("t3_rst_none", none1, 1);
    start1 = 1'b1;
    step();
    start1 = 1'b0; spike1 = 6'b001000;
    repeat (19) step();
    stop1 = 1'b1;
    step();
    stop1 = 1'b0; spike1 = '0;
    check("t3_counting", counting1, 0);
    wait_sv(1, 20, n);
    check("t3_snap_latency", n, 7);
    check("t3_sat", sat1, 6'b001000);
    check("t3_dom_idx", dom1, 3);
    rd(1, 3, 15, "t3_ch3");
    rd(1, 6, 0, "t3_idx6");
    rd(1, 7, 0, "t3_idx7");
    // Second window: no saturation, tie between ch3 and ch5
    start1 = 1'b1;
    step();
    start1 = 1'b0; spike1 = 6'b101000;
    repeat (9) step();
    stop1 = 1'b1;
    step();
    stop1 = 1'b0; spike1 = '0;
    wait_sv(1, 20, n);
    check("t3b_snap_latency", n, 7);
    check("t3b_sat", sat1, 0);
    check("t3b_dom_tie", dom1, 3);
    check("t3b_dom_none", none1, 0);
    rd(1, 3, 10, "t3b_ch3");
    rd(1, 5, 10, "t3b_ch5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
